// File: rtl/memmap_router_pkg.sv
// memmap_router_pkg: shared types, constants and parameter-field helpers for the memory-map router
// Contents:
//   state_t    - access FSM encoding (IDLE, WAIT, DONE)
//   OPEN_BUS   - all-ones read value for unmapped accesses (truncate to DW)
//   get_field  - extract field idx of the given width from a flattened parameter vector
package memmap_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [63:0] OPEN_BUS = '1;

    // Flattened parameters are zero-extended to 256 bits by the caller so one helper
    // serves bases, masks (AW <= 32) and wait counts (width 4) for up to 8 regions.
    function automatic logic [31:0] get_field(input logic [255:0] flat, input int idx, input int width);
        logic [255:0] s;
        s = flat >> (idx * width);
        return 32'(s) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/memmap_router_if.sv
// memmap_router_if: CPU-side and memory-side bus bundle for memmap_router
// Ports (signals):
//   cpu_address/cpu_wdata/cpu_req/cpu_we  - request from the CPU
//   cpu_ready/cpu_rdata                   - completion pulse and registered read data
//   mem_address/mem_wdata/mem_sel/mem_we  - latched access towards the regions
//   mem_q                                 - per-region read data, region 0 in LSBs
// Modports: master = CPU plus memory environment, slave = router.
interface memmap_router_if #(
    parameter int REGIONS = 4,
    parameter int AW      = 20,
    parameter int DW      = 8
);
    logic [AW-1:0]         cpu_address;
    logic [DW-1:0]         cpu_wdata;
    logic                  cpu_req;
    logic                  cpu_we;
    logic                  cpu_ready;
    logic [DW-1:0]         cpu_rdata;
    logic [AW-1:0]         mem_address;
    logic [DW-1:0]         mem_wdata;
    logic [REGIONS-1:0]    mem_sel;
    logic [REGIONS-1:0]    mem_we;
    logic [REGIONS*DW-1:0] mem_q;

    modport master (
        output cpu_address, cpu_wdata, cpu_req, cpu_we, mem_q,
        input  cpu_ready, cpu_rdata, mem_address, mem_wdata, mem_sel, mem_we
    );

    modport slave (
        input  cpu_address, cpu_wdata, cpu_req, cpu_we, mem_q,
        output cpu_ready, cpu_rdata, mem_address, mem_wdata, mem_sel, mem_we
    );
endinterface

// File: rtl/memmap_decode.sv
// memmap_decode: combinational base/mask address decoder with lowest-index priority
// Ports:
//   address - CPU address to decode
//   match   - one-hot winning region (all zero when nothing matches)
//   hit     - at least one enabled region matches
module memmap_decode
    import memmap_router_pkg::*;
#(
    parameter int                  REGIONS     = 4,
    parameter int                  AW          = 20,
    parameter logic [REGIONS*AW-1:0] REGION_BASE = '0,
    parameter logic [REGIONS*AW-1:0] REGION_MASK = '0
) (
    input  logic [AW-1:0]      address,
    output logic [REGIONS-1:0] match,
    output logic               hit
);
    logic [REGIONS-1:0] raw;

    for (genvar i = 0; i < REGIONS; i++) begin : g_region
        localparam logic [AW-1:0] BASE = AW'(get_field(256'(REGION_BASE), i, AW));
        localparam logic [AW-1:0] MASK = AW'(get_field(256'(REGION_MASK), i, AW));
        // A zero mask would match every address, so it marks the region disabled.
        assign raw[i] = (MASK != '0) && ((address & MASK) == (BASE & MASK));
    end

    // Isolate the lowest set bit: overlapping regions resolve to the lowest index.
    assign match = raw & (~raw + REGIONS'(1));
    assign hit   = |raw;
endmodule

// File: rtl/memmap_router.sv
// memmap_router: decodes CPU accesses into memory regions with per-region wait states
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   bus (slave)   - CPU request/completion and per-region memory strobes/data
//   fault, fault_address - sticky fault flag and first faulting address
//                          (present only when MEMMAP_FAULT_EN is defined)
// Build option: define MEMMAP_FAULT_EN to add fault capture for unmapped accesses
// and writes to read-only regions.
module memmap_router
    import memmap_router_pkg::*;
#(
    parameter int                    REGIONS     = 4,
    parameter int                    AW          = 20,
    parameter int                    DW          = 8,
    parameter logic [REGIONS*AW-1:0] REGION_BASE = {20'h00000, 20'hF0000, 20'hB8000, 20'h00000},
    parameter logic [REGIONS*AW-1:0] REGION_MASK = {20'h00000, 20'hFE000, 20'hFE000, 20'hC0000},
    parameter logic [REGIONS*4-1:0]  REGION_WAIT = '0,
    parameter logic [REGIONS-1:0]    REGION_RO   = 4'b0100
) (
    input  logic          clock,
    input  logic          reset,
    memmap_router_if.slave bus
`ifdef MEMMAP_FAULT_EN
    ,
    output logic          fault,
    output logic [AW-1:0] fault_address
`endif
);
    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [REGIONS-1:0] sel_q, sel_d;
    logic               hit_q, hit_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic [REGIONS-1:0] dec_match;
    logic               dec_hit;
    logic [3:0]         dec_wait;
    logic [DW-1:0]      sel_data;
    logic               ro_hit;
    logic               last_wait;
`ifdef MEMMAP_FAULT_EN
    logic               fault_q, fault_d;
    logic [AW-1:0]      fault_address_q, fault_address_d;
`endif

    memmap_decode #(
        .REGIONS     (REGIONS),
        .AW          (AW),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_decode (
        .address (bus.cpu_address),
        .match   (dec_match),
        .hit     (dec_hit)
    );

    // Wait count of the decoded region and read data of the latched region;
    // both selectors are one-hot (or zero), so OR-ing the candidates is a mux.
    always_comb begin
        dec_wait = '0;
        sel_data = '0;
        for (int i = 0; i < REGIONS; i++) begin
            dec_wait = dec_wait | (dec_match[i] ? 4'(get_field(256'(REGION_WAIT), i, 4)) : 4'd0);
            sel_data = sel_data | (sel_q[i] ? bus.mem_q[i*DW +: DW] : '0);
        end
    end

    assign ro_hit    = |(sel_q & REGION_RO);
    assign last_wait = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        sel_d   = sel_q;
        hit_d   = hit_q;
        rdata_d = rdata_q;
`ifdef MEMMAP_FAULT_EN
        fault_d         = fault_q;
        fault_address_d = fault_address_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    state_d = ST_WAIT;
                    cnt_d   = dec_wait;
                    addr_d  = bus.cpu_address;
                    wdata_d = bus.cpu_wdata;
                    we_d    = bus.cpu_we;
                    sel_d   = dec_match;
                    hit_d   = dec_hit;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    rdata_d = we_q ? rdata_q : (hit_q ? sel_data : DW'(OPEN_BUS));
`ifdef MEMMAP_FAULT_EN
                    // Sticky: only the first unmapped or read-only-write access is recorded.
                    if (!fault_q && (!hit_q || (we_q && ro_hit))) begin
                        fault_d         = 1'b1;
                        fault_address_d = addr_q;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                hit_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            hit_q   <= 1'b0;
            rdata_q <= DW'(OPEN_BUS);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            hit_q   <= hit_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEMMAP_FAULT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q         <= 1'b0;
            fault_address_q <= '0;
        end else begin
            fault_q         <= fault_d;
            fault_address_q <= fault_address_d;
        end
    end

    assign fault         = fault_q;
    assign fault_address = fault_address_q;
`endif

    // sel_q is cleared on the way back to IDLE, so mem_sel is zero whenever idle.
    assign bus.cpu_ready   = (state_q == ST_DONE);
    assign bus.cpu_rdata   = rdata_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_sel     = sel_q;
    assign bus.mem_we      = (last_wait && we_q && !ro_hit) ? sel_q : '0;
endmodule

// File: tb/tb_memmap_router.sv
// tb_memmap_router: table-driven and randomized self-checking bench for memmap_router
module tb_memmap_router;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    memmap_router_if #(.REGIONS(4), .AW(20), .DW(8)) bus ();

`ifdef MEMMAP_FAULT_EN
    logic        fault;
    logic [19:0] fault_address;
`endif

    // Region 3 overlaps region 1 (0xB8000-0xB9FFF) so priority is exercised.
    memmap_router #(
        .REGIONS     (4),
        .AW          (20),
        .DW          (8),
        .REGION_BASE ({20'hB8000, 20'hF0000, 20'hB8000, 20'h00000}),
        .REGION_MASK ({20'hF8000, 20'hFE000, 20'hFE000, 20'hC0000}),
        .REGION_WAIT ({4'd5, 4'd0, 4'd3, 4'd0}),
        .REGION_RO   (4'b0100)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef MEMMAP_FAULT_EN
        ,
        .fault         (fault),
        .fault_address (fault_address)
`endif
    );

    localparam logic [19:0] M_BASE [4] = '{20'h00000, 20'hB8000, 20'hF0000, 20'hB8000};
    localparam logic [19:0] M_MASK [4] = '{20'hC0000, 20'hFE000, 20'hFE000, 20'hF8000};
    localparam int          M_WAIT [4] = '{0, 3, 0, 5};
    localparam logic        M_RO   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    typedef struct {
        logic [19:0] a;
        logic        w;
        logic [7:0]  d;
        logic [3:0]  sel;
        int          lat;
        int          wen;
        logic [7:0]  rd;
    } vec_t;

    vec_t        tbl [9];
    logic [7:0]  model_rd;
    logic        mf;
    logic [19:0] mfa;

    function automatic int ref_region(input logic [19:0] a);
        for (int i = 0; i < 4; i++)
            if (M_MASK[i] != 20'h0 && (a & M_MASK[i]) == (M_BASE[i] & M_MASK[i])) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input logic [19:0] a, input logic w, input logic [7:0] d, input logic [3:0] esel,
                       input int elat, input int ewe, input logic [7:0] erd);
        int   lat = 0;
        int   wcnt = 0;
        int   wcyc = 0;
        logic sel_bad = 1'b0;
        @(negedge clock);
        bus.cpu_req = 1'b1;
        bus.cpu_address = a;
        bus.cpu_we = w;
        bus.cpu_wdata = d;
        @(posedge clock);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clock);
            if (k == 1) begin
                bus.cpu_address = ~a;
                bus.cpu_wdata = ~d;
                bus.cpu_we = ~w;
            end
            if (bus.mem_sel !== esel) sel_bad = 1'b1;
            if (|bus.mem_we) begin
                wcnt++;
                wcyc = k;
                if (bus.mem_we !== esel) sel_bad = 1'b1;
            end
            if (bus.cpu_ready) begin
                lat = k;
                bus.cpu_req = 1'b0;
                chk("rdata", 32'(bus.cpu_rdata), 32'(erd));
                chk("mem_address", 32'(bus.mem_address), 32'(a));
                if (w) chk("mem_wdata", 32'(bus.mem_wdata), 32'(d));
            end
        end
        bus.cpu_req = 1'b0;
        chk("latency", 32'(lat), 32'(elat));
        chk("we_pulses", 32'(wcnt), 32'(ewe));
        if (ewe != 0) chk("we_cycle", 32'(wcyc), 32'(elat - 1));
        chk("sel_held", 32'(sel_bad), 32'd0);
        @(negedge clock);
        chk("idle_ready", 32'(bus.cpu_ready), 32'd0);
        chk("idle_sel", 32'(bus.mem_sel), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          r1, r2, nr, nwe;
        logic [19:0] a;
        logic [31:0] q;
        logic        w;
        int          r;
        tbl[0] = '{20'h00010, 1'b0, 8'h00, 4'b0001, 2, 0, 8'h5A};
        tbl[1] = '{20'hB8002, 1'b1, 8'h41, 4'b0010, 5, 1, 8'h5A};
        tbl[2] = '{20'hF0000, 1'b1, 8'h77, 4'b0100, 2, 0, 8'h5A};
        tbl[3] = '{20'hC0000, 1'b0, 8'h00, 4'b0000, 2, 0, 8'hFF};
        tbl[4] = '{20'h01000, 1'b0, 8'h00, 4'b0001, 2, 0, 8'h5A};
        tbl[5] = '{20'hB8002, 1'b0, 8'h00, 4'b0010, 5, 0, 8'h11};
        tbl[6] = '{20'hF1FFF, 1'b0, 8'h00, 4'b0100, 2, 0, 8'h22};
        tbl[7] = '{20'hBC000, 1'b0, 8'h00, 4'b1000, 7, 0, 8'h33};
        tbl[8] = '{20'hBC000, 1'b1, 8'hAA, 4'b1000, 7, 1, 8'h33};
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_wdata = '0;
        bus.mem_q = 32'h3322115A;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_sel", 32'(bus.mem_sel), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_rdata", 32'(bus.cpu_rdata), 32'hFF);
        chk("rst_address", 32'(bus.mem_address), 32'd0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 9; i++)
            run(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].sel, tbl[i].lat, tbl[i].wen, tbl[i].rd);
`ifdef MEMMAP_FAULT_EN
        chk("fault_set", 32'(fault), 32'd1);
        chk("fault_first_addr", 32'(fault_address), 32'hF0000);
`endif
        // Reset while a 5-wait write to region 3 is still counting down.
        @(negedge clock);
        bus.cpu_req = 1'b1;
        bus.cpu_address = 20'hBC000;
        bus.cpu_we = 1'b1;
        bus.cpu_wdata = 8'h55;
        @(posedge clock);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("abort_ready", 32'(bus.cpu_ready), 32'd0);
        chk("abort_sel", 32'(bus.mem_sel), 32'd0);
        chk("abort_rdata", 32'(bus.cpu_rdata), 32'hFF);
        nr = 0;
        nwe = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            nr += int'(bus.cpu_ready);
            nwe += int'(|bus.mem_we);
        end
        chk("abort_no_ready", 32'(nr), 32'd0);
        chk("abort_no_we", 32'(nwe), 32'd0);
`ifdef MEMMAP_FAULT_EN
        chk("fault_cleared", 32'(fault), 32'd0);
`endif
        // Request held high through DONE: the DONE cycle must not start a new access.
        @(negedge clock);
        bus.cpu_req = 1'b1;
        bus.cpu_address = 20'h00010;
        bus.cpu_we = 1'b0;
        @(posedge clock);
        nr = 0;
        r1 = 0;
        r2 = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (bus.cpu_ready) begin
                nr++;
                if (nr == 1) r1 = k;
                else r2 = k;
                if (nr == 2) bus.cpu_req = 1'b0;
            end
        end
        bus.cpu_req = 1'b0;
        chk("b2b_count", 32'(nr), 32'd2);
        chk("b2b_first", 32'(r1), 32'd2);
        chk("b2b_second", 32'(r2), 32'd5);
        model_rd = 8'h5A;
        mf = 1'b0;
        mfa = '0;
        for (int n = 0; n < 80; n++) begin
            logic [19:0] bases [6];
            bases = '{20'h00000, 20'hB8000, 20'hF0000, 20'hBC000, 20'hC0000, 20'h00000};
            r = int'($urandom_range(0, 5));
            a = (r == 5) ? 20'($urandom) : (bases[r] | 20'($urandom & 32'h01FFF));
            q = $urandom;
            w = 1'($urandom_range(0, 1));
            bus.mem_q = q;
            r = ref_region(a);
            if (!w) model_rd = (r < 0) ? 8'hFF : q[r*8 +: 8];
            if (!mf && (r < 0 || (w && M_RO[r]))) begin
                mf = 1'b1;
                mfa = a;
            end
            run(a, w, 8'($urandom), (r < 0) ? 4'b0000 : 4'(1 << r), ((r < 0) ? 0 : M_WAIT[r]) + 2,
                (w && r >= 0 && !M_RO[r]) ? 1 : 0, model_rd);
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end
`ifdef MEMMAP_FAULT_EN
        chk("rand_fault", 32'(fault), 32'(mf));
        if (mf) chk("rand_fault_addr", 32'(fault_address), 32'(mfa));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
